// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the sram request arbiter.
//   - owner encodings carried in the in-order owner FIFO
//   - sram-like transfer size encodings
//   - bundle of shared-port request attributes
//   - grant-lock state encoding
package sram_req_arbiter_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cache;
  } mem_attr_t;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order owner FIFO: one {owner, drop} entry per accepted request.
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointers/count only)
//   push_i          store push_owner_i at the write pointer
//   push_owner_i    owner of the entry being pushed
//   pop_i           retire the head entry
//   flush_i         mark every stored inst entry (and a same-cycle inst push) as drop
//   head_owner_o    owner of the head entry
//   head_drop_o     stored drop flag of the head entry
//   full_o, empty_o occupancy flags
module sram_req_arbiter_owner_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_owner_i,
  input  logic pop_i,
  input  logic flush_i,
  output logic head_owner_o,
  output logic head_drop_o,
  output logic full_o,
  output logic empty_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] owner_q, owner_d;
  logic [DEPTH-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    owner_d  = owner_q;
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Marking unoccupied slots is harmless: a later push rewrites drop.
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (owner_q[i] == OWN_INST) drop_d[i] = 1'b1;
      end
    end

    if (push_i) begin
      owner_d[wr_ptr_q] = push_owner_i;
      drop_d[wr_ptr_q]  = flush_i && (push_owner_i == OWN_INST);
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    if (pop_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    drop_q  <= drop_d;
  end

  assign head_owner_o = owner_q[rd_ptr_q];
  assign head_drop_o  = drop_q[rd_ptr_q];
  assign full_o       = (count_q == FULL_CNT);
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between instruction fetch and data requesters.
// One grant per cycle; every accepted request's owner is queued in order so
// each mem_data_ok_i is steered back to its requester. Fetch responses
// outstanding at an inst_flush_i are swallowed.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants between the two
// requesters (last_owner register, reset to data) instead of fixed data priority.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   inst_*_i / inst_*_o          fetch request side (64-bit read data)
//   data_*_i / data_*_o          load/store request side (32-bit read data)
//   mem_*_o / mem_*_i            shared sram-like port
//   arb_err_o                    sticky: response arrived with nothing outstanding
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int PTR_W           = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_cache_i,
  input  logic        inst_flush_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [63:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_cache_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [1:0]  mem_size_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_cache_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [63:0] mem_rdata_i,
  output logic        arb_err_o
);

  lock_state_t state_q, state_d;
  logic        lock_owner_q, lock_owner_d;
  mem_attr_t   attr_q, attr_d;
  logic        arb_err_q, arb_err_d;

  logic        gnt_vld;
  logic        gnt_owner;
  mem_attr_t   mem_attr;
  logic        accept;
  logic        pop;
  logic        drop_eff;
  logic        fifo_full, fifo_empty;
  logic        head_owner, head_drop;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_owner_q, last_owner_d;
`endif

  // Grant selection. A locked request keeps its owner regardless of the
  // other side; issue is blocked at full even if a pop happens this cycle.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_owner = OWN_DATA;
    if (state_q == ST_LOCKED) begin
      gnt_vld   = 1'b1;
      gnt_owner = lock_owner_q;
    end else if (!fifo_full) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (data_req_i && inst_req_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = ~last_owner_q;
      end else if (data_req_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = OWN_DATA;
      end else if (inst_req_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = OWN_INST;
      end
`else
      if (data_req_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = OWN_DATA;
      end else if (inst_req_i) begin
        gnt_vld   = 1'b1;
        gnt_owner = OWN_INST;
      end
`endif
    end
  end

  // Attributes come from the captured copy while locked so the port stays
  // stable even if the other requester's inputs move.
  always_comb begin
    mem_attr = '0;
    if (state_q == ST_LOCKED) begin
      mem_attr = attr_q;
    end else if (gnt_vld) begin
      if (gnt_owner == OWN_DATA) begin
        mem_attr.wr    = data_wr_i;
        mem_attr.size  = data_size_i;
        mem_attr.addr  = data_addr_i;
        mem_attr.wdata = data_wdata_i;
        mem_attr.cache = data_cache_i;
      end else begin
        mem_attr.wr    = 1'b0;
        mem_attr.size  = SIZE_WORD;
        mem_attr.addr  = inst_addr_i;
        mem_attr.wdata = 32'd0;
        mem_attr.cache = inst_cache_i;
      end
    end
  end

  assign mem_req_o   = gnt_vld;
  assign mem_wr_o    = mem_attr.wr;
  assign mem_size_o  = mem_attr.size;
  assign mem_addr_o  = mem_attr.addr;
  assign mem_wdata_o = mem_attr.wdata;
  assign mem_cache_o = mem_attr.cache;

  assign accept         = gnt_vld && mem_addr_ok_i;
  assign inst_addr_ok_o = accept && (gnt_owner == OWN_INST);
  assign data_addr_ok_o = accept && (gnt_owner == OWN_DATA);

  // Grant lock FSM
  always_comb begin
    state_d      = state_q;
    lock_owner_d = gnt_owner;
    attr_d       = mem_attr;
    case (state_q)
      ST_OPEN:   if (gnt_vld && !mem_addr_ok_i) state_d = ST_LOCKED;
      ST_LOCKED: if (mem_addr_ok_i) state_d = ST_OPEN;
      default:   state_d = ST_OPEN;
    endcase
  end

  // A flush in the pop cycle also suppresses the head response.
  assign pop            = mem_data_ok_i && !fifo_empty;
  assign drop_eff       = head_drop || inst_flush_i;
  assign data_data_ok_o = pop && (head_owner == OWN_DATA);
  assign inst_data_ok_o = pop && (head_owner == OWN_INST) && !drop_eff;
  assign data_rdata_o   = data_data_ok_o ? mem_rdata_i[31:0] : 32'd0;
  assign inst_rdata_o   = inst_data_ok_o ? mem_rdata_i : 64'd0;

  assign arb_err_d = arb_err_q || (mem_data_ok_i && fifo_empty);
  assign arb_err_o = arb_err_q;

`ifdef ARB_ROUND_ROBIN_EN
  assign last_owner_d = accept ? gnt_owner : last_owner_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      arb_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_DATA;
`endif
    end else begin
      state_q   <= state_d;
      arb_err_q <= arb_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    lock_owner_q <= lock_owner_d;
    attr_q       <= attr_d;
  end

  sram_req_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .PTR_W (PTR_W)
  ) u_owner_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (accept),
    .push_owner_i (gnt_owner),
    .pop_i        (pop),
    .flush_i      (inst_flush_i),
    .head_owner_o (head_owner),
    .head_drop_o  (head_drop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
`timescale 1ns/1ps
module tb_sram_req_arbiter;

  localparam int  MAXO = 4;
  localparam logic I = 1'b0;
  localparam logic D = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] IA = 32'h1000_0008;
  localparam logic [31:0] DA = 32'h2000_0004;
  localparam logic [63:0] R1 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] R2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] R3 = 64'h5555_6666_7777_8888;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_i, inst_cache_i, inst_flush_i;
  logic [31:0] inst_addr_i;
  logic        inst_addr_ok_o, inst_data_ok_o;
  logic [63:0] inst_rdata_o;
  logic        data_req_i, data_wr_i, data_cache_i;
  logic [1:0]  data_size_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_addr_ok_o, data_data_ok_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_wr_o, mem_cache_o;
  logic [1:0]  mem_size_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_addr_ok_i, mem_data_ok_i;
  logic [63:0] mem_rdata_i;
  logic        arb_err_o;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUTSTANDING(MAXO), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_cache_i(inst_cache_i),
    .inst_flush_i(inst_flush_i), .inst_addr_ok_o(inst_addr_ok_o),
    .inst_data_ok_o(inst_data_ok_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_size_i(data_size_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_cache_i(data_cache_i),
    .data_addr_ok_o(data_addr_ok_o), .data_data_ok_o(data_data_ok_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_size_o(mem_size_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_cache_o(mem_cache_o),
    .mem_addr_ok_i(mem_addr_ok_i), .mem_data_ok_i(mem_data_ok_i),
    .mem_rdata_i(mem_rdata_i), .arb_err_o(arb_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic fl, input logic ao,
                       input logic dk, input logic [63:0] rd);
    inst_req_i    = ir;
    data_req_i    = dr;
    inst_flush_i  = fl;
    mem_addr_ok_i = ao;
    mem_data_ok_i = dk;
    mem_rdata_i   = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ir, dr, fl, ao, dk;
    logic [63:0] rd;
    logic        e_req, e_iaok, e_daok, e_idok, e_ddok;
    logic [31:0] e_addr;
    logic [63:0] e_irdata;
    logic [31:0] e_drdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, dr, fl, ao, dk, input logic [63:0] rd,
                              input logic er, eia, eda, eid, edd, input logic [31:0] ea,
                              input logic [63:0] eir, input logic [31:0] edr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.fl = fl; v.ao = ao; v.dk = dk; v.rd = rd;
    v.e_req = er; v.e_iaok = eia; v.e_daok = eda; v.e_idok = eid; v.e_ddok = edd;
    v.e_addr = ea; v.e_irdata = eir; v.e_drdata = edr;
    return v;
  endfunction

  typedef struct { logic owner; logic drop; } ent_t;

  vec_t tbl[20];
  logic g[5];

  initial begin
    logic        e_req, own, e_iaok, e_daok, e_idok, e_ddok, exp_resp;
    logic [35:0] e_attr;
    logic [31:0] e_wdata;
    logic [63:0] e_irdata;
    logic [31:0] e_drdata;
    logic [31:0] r;
    ent_t        q[$];
    ent_t        h;
    bit          m_locked;
    logic        m_lock_owner, m_last;

    // ---------------- reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 64'd0);
    inst_addr_i = IA; inst_cache_i = 1'b1;
    data_addr_i = DA; data_wr_i = 1'b0; data_size_i = 2'd2;
    data_wdata_i = 32'hDEAD_BEEF; data_cache_i = 1'b1;
    repeat (3) tick();
    check("rst mem_req", mem_req_o, 0);
    check("rst addr_ok", {inst_addr_ok_o, data_addr_ok_o}, 0);
    check("rst data_ok", {inst_data_ok_o, data_data_ok_o}, 0);
    check("rst mem_attr", {mem_wr_o, mem_size_o, mem_addr_o, mem_wdata_o, mem_cache_o}, 0);
    check("rst arb_err", arb_err_o, 0);
    rst = 1'b0;

    // ---------------- table-driven vectors
    //            ir dr fl ao dk rdata  req ia da id dd addr irdata drdata
    tbl[0]  = mk(0, 1, 0, 1, 0, 64'd0, 1, 0, 1, 0, 0, DA, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 1, R1,    1, 1, 0, 0, 1, IA, 0, 32'hCCCC_DDDD);
    tbl[2]  = mk(0, 0, 0, 0, 1, R2,    0, 0, 0, 1, 0, 0,  R2, 0);
    tbl[3]  = mk(1, 0, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, IA, 0, 0);
    tbl[4]  = mk(1, 0, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, IA, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, IA, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, IA, 0, 0);
    tbl[7]  = mk(1, 0, 0, 1, 0, 64'd0, 0, 0, 0, 0, 0, 0,  0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 1, R3,    0, 0, 0, 1, 0, 0,  R3, 0);
    tbl[9]  = mk(1, 0, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, IA, 0, 0);
    tbl[10] = mk(0, 0, 1, 0, 1, R1,    0, 0, 0, 0, 0, 0,  0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, R1,    0, 0, 0, 0, 0, 0,  0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, R1,    0, 0, 0, 0, 0, 0,  0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, R1,    0, 0, 0, 0, 0, 0,  0, 0);
    tbl[14] = mk(1, 0, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, IA, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 1, R2,    0, 0, 0, 1, 0, 0,  R2, 0);
    tbl[16] = mk(1, 0, 0, 1, 0, 64'd0, 1, 1, 0, 0, 0, IA, 0, 0);
    tbl[17] = mk(1, 0, 1, 1, 1, R3,    1, 1, 0, 0, 0, IA, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 1, R3,    0, 0, 0, 0, 0, 0,  0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0,  0, 0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].ir, tbl[i].dr, tbl[i].fl, tbl[i].ao, tbl[i].dk, tbl[i].rd);
      #3;
      check($sformatf("tbl%0d mem_req", i), mem_req_o, tbl[i].e_req);
      check($sformatf("tbl%0d mem_addr", i), mem_addr_o, tbl[i].e_addr);
      check($sformatf("tbl%0d inst_addr_ok", i), inst_addr_ok_o, tbl[i].e_iaok);
      check($sformatf("tbl%0d data_addr_ok", i), data_addr_ok_o, tbl[i].e_daok);
      check($sformatf("tbl%0d inst_data_ok", i), inst_data_ok_o, tbl[i].e_idok);
      check($sformatf("tbl%0d data_data_ok", i), data_data_ok_o, tbl[i].e_ddok);
      check($sformatf("tbl%0d inst_rdata", i), inst_rdata_o, tbl[i].e_irdata);
      check($sformatf("tbl%0d data_rdata", i), data_rdata_o, tbl[i].e_drdata);
      check($sformatf("tbl%0d arb_err", i), arb_err_o, 0);
      tick();
    end

    // ---------------- grant lock: inst held off by addr_ok=0, data arrives mid-lock
    drive(1, 0, 0, 0, 0, 64'd0);
    #3;
    check("lock c0 mem_req", mem_req_o, 1);
    check("lock c0 addr", mem_addr_o, IA);
    check("lock c0 iaok", inst_addr_ok_o, 0);
    tick();
    data_wr_i = 1'b1;
    for (int c = 1; c < 3; c++) begin
      drive(1, 1, 0, 0, 0, 64'd0);
      #3;
      check($sformatf("lock c%0d addr", c), mem_addr_o, IA);
      check($sformatf("lock c%0d wr", c), mem_wr_o, 0);
      check($sformatf("lock c%0d aok", c), {inst_addr_ok_o, data_addr_ok_o}, 2'b00);
      tick();
    end
    drive(1, 1, 0, 1, 0, 64'd0);
    #3;
    check("lock c3 addr", mem_addr_o, IA);
    check("lock c3 aok", {inst_addr_ok_o, data_addr_ok_o}, 2'b10);
    tick();
    drive(0, 1, 0, 1, 0, 64'd0);
    #3;
    check("lock c4 addr", mem_addr_o, DA);
    check("lock c4 wr", mem_wr_o, 1);
    check("lock c4 aok", {inst_addr_ok_o, data_addr_ok_o}, 2'b01);
    tick();
    drive(0, 0, 0, 0, 1, R1);
    #3;
    check("lock c5 inst_rdata", inst_rdata_o, R1);
    check("lock c5 ok", {inst_data_ok_o, data_data_ok_o}, 2'b10);
    tick();
    drive(0, 0, 0, 0, 1, R2);
    #3;
    check("lock c6 data_rdata", data_rdata_o, R2[31:0]);
    check("lock c6 ok", {inst_data_ok_o, data_data_ok_o}, 2'b01);
    tick();
    data_wr_i = 1'b0;

    // ---------------- both requesting continuously
    g[0] = I;
    for (int k = 1; k < 5; k++) g[k] = RR ? ((k % 2 == 1) ? D : I) : D;
    drive(1, 0, 0, 1, 0, 64'd0);
    #3;
    check("prio p0 aok", {inst_addr_ok_o, data_addr_ok_o}, 2'b10);
    tick();
    for (int k = 1; k < 5; k++) begin
      drive(1, 1, 0, 1, 1, R3);
      #3;
      check($sformatf("prio p%0d grant", k), {inst_addr_ok_o, data_addr_ok_o},
            (g[k] == D) ? 2'b01 : 2'b10);
      check($sformatf("prio p%0d resp", k), {inst_data_ok_o, data_data_ok_o},
            (g[k-1] == D) ? 2'b01 : 2'b10);
      tick();
    end
    drive(0, 0, 0, 0, 1, R3);
    #3;
    check("prio p5 resp", {inst_data_ok_o, data_data_ok_o}, (g[4] == D) ? 2'b01 : 2'b10);
    tick();

    // ---------------- spurious response on empty FIFO
    drive(0, 0, 0, 0, 1, R1);
    #3;
    check("err c0 ok", {inst_data_ok_o, data_data_ok_o}, 2'b00);
    tick();
    drive(0, 0, 0, 0, 0, 64'd0);
    #3;
    check("err c1 arb_err", arb_err_o, 1);
    tick();
    #3;
    check("err c2 arb_err", arb_err_o, 1);
    rst = 1'b1;
    tick();
    check("err rst arb_err", arb_err_o, 0);
    rst = 1'b0;

    // ---------------- randomized against reference model
    m_locked = 0; m_lock_owner = I; m_last = D;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!(m_locked && m_lock_owner == I)) begin
        inst_req_i = 1'($urandom_range(0, 1));
        r = $urandom;
        inst_addr_i = r & 32'hFFFF_FFF8;
        inst_cache_i = 1'($urandom_range(0, 1));
      end
      if (!(m_locked && m_lock_owner == D)) begin
        data_req_i = 1'($urandom_range(0, 1));
        data_addr_i = $urandom;
        data_wdata_i = $urandom;
        data_wr_i = 1'($urandom_range(0, 1));
        data_size_i = 2'($urandom_range(0, 2));
        data_cache_i = 1'($urandom_range(0, 1));
      end
      inst_flush_i  = ($urandom_range(0, 9) == 0);
      mem_addr_ok_i = ($urandom_range(0, 2) != 0);
      mem_data_ok_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i   = {$urandom, $urandom};
      #3;

      e_req = 0; own = D;
      if (m_locked) begin
        e_req = 1; own = m_lock_owner;
      end else if (q.size() < MAXO) begin
        if (inst_req_i && data_req_i) begin e_req = 1; own = RR ? ~m_last : D; end
        else if (data_req_i) begin e_req = 1; own = D; end
        else if (inst_req_i) begin e_req = 1; own = I; end
      end
      if (!e_req) begin
        e_attr = '0; e_wdata = '0;
      end else if (own == D) begin
        e_attr = {data_wr_i, data_size_i, data_addr_i, data_cache_i}; e_wdata = data_wdata_i;
      end else begin
        e_attr = {1'b0, 2'd2, inst_addr_i, inst_cache_i}; e_wdata = 32'd0;
      end
      e_iaok = e_req && mem_addr_ok_i && (own == I);
      e_daok = e_req && mem_addr_ok_i && (own == D);
      e_idok = 0; e_ddok = 0;
      if (mem_data_ok_i) begin
        h = q[0];
        e_ddok = (h.owner == D);
        e_idok = (h.owner == I) && !(h.drop || inst_flush_i);
      end
      e_irdata = e_idok ? mem_rdata_i : 64'd0;
      e_drdata = e_ddok ? mem_rdata_i[31:0] : 32'd0;

      check("rnd mem_req", mem_req_o, e_req);
      check("rnd attr", {mem_wr_o, mem_size_o, mem_addr_o, mem_cache_o}, e_attr);
      check("rnd wdata", mem_wdata_o, e_wdata);
      check("rnd addr_ok", {inst_addr_ok_o, data_addr_ok_o}, {e_iaok, e_daok});
      check("rnd data_ok", {inst_data_ok_o, data_data_ok_o}, {e_idok, e_ddok});
      check("rnd inst_rdata", inst_rdata_o, e_irdata);
      check("rnd data_rdata", data_rdata_o, e_drdata);
      check("rnd arb_err", arb_err_o, 0);

      exp_resp = mem_data_ok_i;
      tick();
      if (exp_resp) void'(q.pop_front());
      if (inst_flush_i) begin
        foreach (q[i]) if (q[i].owner == I) q[i].drop = 1'b1;
      end
      if (e_req && mem_addr_ok_i) begin
        h.owner = own;
        h.drop  = inst_flush_i && (own == I);
        q.push_back(h);
        m_last = own;
      end
      m_locked = e_req && !mem_addr_ok_i;
      m_lock_owner = own;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
